// File: rtl/myproject_mac_pipe.sv
// Pipelined multiply-accumulate: reduces a framed stream of din0*din1 products to one
// rounded, shifted and saturated dot-product per frame, NUM_STAGE ce-cycles after the last sample.
module myproject_mac_pipe #(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 32,
    parameter int ACC_WIDTH  = 64,
    parameter int DOUT_WIDTH = 58,
    parameter int NUM_STAGE  = 5,
    parameter int SHIFT      = 0,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
    localparam int RW  = ACC_WIDTH + 1;
    localparam int DLY = NUM_STAGE - 2;
    localparam logic [RW-1:0] HALF = ({{(RW-1){1'b0}}, 1'b1} << SHIFT) >> 1;

    logic [DIN0_WIDTH-1:0] din0_q;
    logic [DIN1_WIDTH-1:0] din1_q;
    logic                  s1Valid_q;
    logic                  s1First_q;
    logic                  s1Last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din0_q    <= '0;
            din1_q    <= '0;
            s1Valid_q <= 1'b0;
            s1First_q <= 1'b0;
            s1Last_q  <= 1'b0;
        end else if (ce) begin
            din0_q    <= din0;
            din1_q    <= din1;
            s1Valid_q <= in_valid;
            s1First_q <= in_first;
            s1Last_q  <= in_last;
        end
    end

    // Extending both operands to the full product width makes the low PW bits of a
    // plain multiply equal the exact signed or unsigned product.
    logic [PW-1:0] opA;
    logic [PW-1:0] opB;
    logic [PW-1:0] prod;

    generate
        if (SIGNED != 0) begin : gSignExt
            assign opA = {{DIN1_WIDTH{din0_q[DIN0_WIDTH-1]}}, din0_q};
            assign opB = {{DIN0_WIDTH{din1_q[DIN1_WIDTH-1]}}, din1_q};
        end else begin : gZeroExt
            assign opA = {{DIN1_WIDTH{1'b0}}, din0_q};
            assign opB = {{DIN0_WIDTH{1'b0}}, din1_q};
        end
    endgenerate

    assign prod = opA * opB;

    logic [PW-1:0] accProd;
    logic          accValid;
    logic          accFirst;
    logic          accLast;

    generate
        if (DLY == 0) begin : gNoDelay
            assign accProd  = prod;
            assign accValid = s1Valid_q;
            assign accFirst = s1First_q;
            assign accLast  = s1Last_q;
        end else begin : gDelay
            logic [PW-1:0]  pipeProd_q [DLY];
            logic [DLY-1:0] pipeValid_q;
            logic [DLY-1:0] pipeFirst_q;
            logic [DLY-1:0] pipeLast_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DLY; i++) begin
                        pipeProd_q[i] <= '0;
                    end
                    pipeValid_q <= '0;
                    pipeFirst_q <= '0;
                    pipeLast_q  <= '0;
                end else if (ce) begin
                    pipeProd_q[0]  <= prod;
                    pipeValid_q[0] <= s1Valid_q;
                    pipeFirst_q[0] <= s1First_q;
                    pipeLast_q[0]  <= s1Last_q;
                    for (int i = 1; i < DLY; i++) begin
                        pipeProd_q[i]  <= pipeProd_q[i-1];
                        pipeValid_q[i] <= pipeValid_q[i-1];
                        pipeFirst_q[i] <= pipeFirst_q[i-1];
                        pipeLast_q[i]  <= pipeLast_q[i-1];
                    end
                end
            end

            assign accProd  = pipeProd_q[DLY-1];
            assign accValid = pipeValid_q[DLY-1];
            assign accFirst = pipeFirst_q[DLY-1];
            assign accLast  = pipeLast_q[DLY-1];
        end
    endgenerate

    logic [ACC_WIDTH-1:0] prodExt;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

    generate
        if (SIGNED != 0) begin : gAccSigned
            assign prodExt = ACC_WIDTH'($signed(accProd));
        end else begin : gAccUnsigned
            assign prodExt = ACC_WIDTH'(accProd);
        end
    endgenerate

    assign acc_d = accFirst ? prodExt : acc_q + prodExt;

    // Rounding is done one bit wider than the accumulator so adding the half-LSB never wraps.
    logic [DOUT_WIDTH-1:0] res;
    logic                  resOvf;

    generate
        if (SIGNED != 0) begin : gOutSigned
            logic signed [RW-1:0] wideS;
            logic signed [RW-1:0] sumS;
            logic signed [RW-1:0] rS;
            logic                 fitsS;

            assign wideS  = RW'($signed(acc_d));
            assign sumS   = wideS + $signed(HALF);
            assign rS     = sumS >>> SHIFT;
            assign fitsS  = (&rS[RW-1:DOUT_WIDTH-1]) | ~(|rS[RW-1:DOUT_WIDTH-1]);
            assign res    = fitsS ? rS[DOUT_WIDTH-1:0]
                          : (rS[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DOUT_WIDTH-1){1'b1}}});
            assign resOvf = ~fitsS;
        end else begin : gOutUnsigned
            logic [RW-1:0] sumU;
            logic [RW-1:0] rU;
            logic          fitsU;

            assign sumU   = {1'b0, acc_d} + HALF;
            assign rU     = sumU >> SHIFT;
            assign fitsU  = ~(|rU[RW-1:DOUT_WIDTH]);
            assign res    = fitsU ? rU[DOUT_WIDTH-1:0] : '1;
            assign resOvf = ~fitsU;
        end
    endgenerate

    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  outValid_q;
    logic                  ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            dout_q     <= '0;
            outValid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (ce) begin
            outValid_q <= 1'b0;
            ovf_q      <= 1'b0;
            if (accValid) begin
                acc_q <= acc_d;
                if (accLast) begin
                    outValid_q <= 1'b1;
                    dout_q     <= res;
                    ovf_q      <= resOvf;
                end
            end
        end
    end

    assign out_valid = outValid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Directed bench for myproject_mac_pipe: defaults instance plus a shifted/narrow-output
// instance and an unsigned full-width instance, all driven from one shared stimulus stream.
module tb_myproject_mac_pipe;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        inValid;
    logic        inFirst;
    logic        inLast;
    logic [31:0] din0;
    logic [31:0] din1;

    logic        outValidA;
    logic [57:0] doutA;
    logic        ovfA;
    logic        outValidB;
    logic [15:0] doutB;
    logic        ovfB;
    logic        outValidC;
    logic [63:0] doutC;
    logic        ovfC;

    int checks = 0;
    int errors = 0;

    myproject_mac_pipe dutA (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(inValid), .in_first(inFirst), .in_last(inLast),
        .din0(din0), .din1(din1),
        .out_valid(outValidA), .dout(doutA), .ovf(ovfA)
    );

    myproject_mac_pipe #(.DOUT_WIDTH(16), .SHIFT(4)) dutB (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(inValid), .in_first(inFirst), .in_last(inLast),
        .din0(din0), .din1(din1),
        .out_valid(outValidB), .dout(doutB), .ovf(ovfB)
    );

    myproject_mac_pipe #(.SIGNED(0), .DOUT_WIDTH(64), .ACC_WIDTH(64)) dutC (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(inValid), .in_first(inFirst), .in_last(inLast),
        .din0(din0), .din1(din1),
        .out_valid(outValidC), .dout(doutC), .ovf(ovfC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] z58(input logic signed [63:0] v);
        return {6'b0, v[57:0]};
    endfunction

    function automatic logic [63:0] z16(input logic signed [63:0] v);
        return {48'b0, v[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and let it be captured by the next rising edge.
    task automatic applyStimulus(input logic v, input logic f, input logic l,
                                 input logic [31:0] a, input logic [31:0] b);
        inValid = v;
        inFirst = f;
        inLast  = l;
        din0    = a;
        din1    = b;
        tick();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset   = 1'b1;
        ce      = 1'b1;
        inValid = 1'b0;
        inFirst = 1'b0;
        inLast  = 1'b0;
        din0    = 32'd0;
        din1    = 32'd0;

        #12;
        checkOutput("reset_validA", 64'(outValidA), 64'd0);
        checkOutput("reset_doutA",  64'(doutA),     64'd0);
        checkOutput("reset_ovfA",   64'(ovfA),      64'd0);
        checkOutput("reset_doutC",  doutC,          64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single signed product");
        applyStimulus(1'b1, 1'b1, 1'b1, -32'sd3, 32'd7);
        idleCycles(3);
        checkOutput("t1_valid_c4", 64'(outValidA), 64'd0);
        idleCycles(1);
        checkOutput("t1_valid_c5", 64'(outValidA), 64'd1);
        checkOutput("t1_dout_c5",  64'(doutA),     z58(-64'sd21));
        checkOutput("t1_ovf_c5",   64'(ovfA),      64'd0);
        idleCycles(1);
        checkOutput("t1_valid_c6", 64'(outValidA), 64'd0);
        checkOutput("t1_hold_c6",  64'(doutA),     z58(-64'sd21));

        $display("[TB] back-to-back frames");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd2, 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd4, 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b1, -32'sd1, 32'd6);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd10, 32'd10);
        idleCycles(3);
        checkOutput("t2_valid_c7", 64'(outValidA), 64'd1);
        checkOutput("t2_dout_c7",  64'(doutA),     64'd20);
        idleCycles(1);
        checkOutput("t2_valid_c8", 64'(outValidA), 64'd1);
        checkOutput("t2_dout_c8",  64'(doutA),     64'd100);
        idleCycles(1);
        checkOutput("t2_valid_c9", 64'(outValidA), 64'd0);

        $display("[TB] rounding shift and saturation");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd24, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, -32'sd24, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd40000, 32'd16);
        idleCycles(2);
        checkOutput("t3_validB_pos", 64'(outValidB), 64'd1);
        checkOutput("t3_doutB_pos",  64'(doutB),     z16(64'sd2));
        checkOutput("t3_ovfB_pos",   64'(ovfB),      64'd0);
        idleCycles(1);
        checkOutput("t3_doutB_neg",  64'(doutB),     z16(-64'sd1));
        checkOutput("t3_ovfB_neg",   64'(ovfB),      64'd0);
        idleCycles(1);
        checkOutput("t3_doutB_sat",  64'(doutB),     z16(64'sd32767));
        checkOutput("t3_ovfB_sat",   64'(ovfB),      64'd1);
        idleCycles(1);
        checkOutput("t3_ovfB_clear", 64'(ovfB),      64'd0);
        checkOutput("t3_doutB_hold", 64'(doutB),     z16(64'sd32767));

        $display("[TB] extreme operands");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idleCycles(3);
        checkOutput("t4_doutA_sat",  64'(doutA),     64'h01FF_FFFF_FFFF_FFFF);
        checkOutput("t4_ovfA_sat",   64'(ovfA),      64'd1);
        checkOutput("t4_validC",     64'(outValidC), 64'd1);
        checkOutput("t4_doutC_2p62", doutC,          64'h4000_0000_0000_0000);
        checkOutput("t4_ovfC_2p62",  64'(ovfC),      64'd0);
        idleCycles(1);
        checkOutput("t4_doutA_one",  64'(doutA),     64'd1);
        checkOutput("t4_ovfA_one",   64'(ovfA),      64'd0);
        checkOutput("t4_doutC_max",  doutC,          64'hFFFF_FFFE_0000_0001);
        checkOutput("t4_ovfC_max",   64'(ovfC),      64'd0);

        $display("[TB] clock-enable stall and bubble");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd1, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
        ce = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 32'd99, 32'd99);
        ce = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd7, 32'd7);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd1, 32'd1);
        idleCycles(3);
        checkOutput("t5_valid_c4", 64'(outValidA), 64'd0);
        idleCycles(1);
        checkOutput("t5_valid_c5", 64'(outValidA), 64'd1);
        checkOutput("t5_dout_c5",  64'(doutA),     64'd3);
        ce = 1'b0;
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 32'd50, 32'd50);
        checkOutput("t5_valid_stall", 64'(outValidA), 64'd1);
        checkOutput("t5_dout_stall",  64'(doutA),     64'd3);
        ce = 1'b1;
        idleCycles(1);
        checkOutput("t5_valid_after", 64'(outValidA), 64'd0);
        checkOutput("t5_dout_after",  64'(doutA),     64'd3);

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd3, 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd4, 32'd4);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t6_doutA_rst",  64'(doutA),     64'd0);
        checkOutput("t6_validA_rst", 64'(outValidA), 64'd0);
        checkOutput("t6_ovfA_rst",   64'(ovfA),      64'd0);
        checkOutput("t6_doutB_rst",  64'(doutB),     64'd0);
        #2;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd5, 32'd5);
        idleCycles(3);
        checkOutput("t6_valid_c4", 64'(outValidA), 64'd0);
        idleCycles(1);
        checkOutput("t6_valid_c5", 64'(outValidA), 64'd1);
        checkOutput("t6_dout_c5",  64'(doutA),     64'd25);
        checkOutput("t6_ovf_c5",   64'(ovfA),      64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
